// File: rtl/div_seq.sv
// Sequential RV32M divide/remainder unit. It uses a restoring shift-subtract
// algorithm that produces one quotient bit per cycle, and it bypasses the loop
// for divide-by-zero and signed overflow.
//
// state | meaning
// IDLE  | waiting for start; captures op and operands
// RUN   | 32 shift-subtract iterations, busy=1
// DONE  | one-cycle done pulse, result valid
module div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_next;

    logic        rem_op_q;
    logic        neg_q_q;
    logic        neg_r_q;
    logic [31:0] rem_q;
    logic [31:0] quot_q;
    logic [31:0] dvsr_q;
    logic [5:0]  cnt_q;
    logic [31:0] result_q;

    logic        is_signed;
    logic        div_zero;
    logic        sgn_ovf;
    logic        special;
    logic [31:0] abs_dividend;
    logic [31:0] abs_divisor;

    assign is_signed    = ~op[0];
    assign div_zero     = (divisor == 32'd0);
    assign sgn_ovf      = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
    assign special      = div_zero || sgn_ovf;
    assign abs_dividend = (is_signed && dividend[31]) ? -dividend : dividend;
    assign abs_divisor  = (is_signed && divisor[31])  ? -divisor  : divisor;

    // The 33-bit partial remainder is the shifted value. After a restore step it
    // always fits in 32 bits again, so only 32 bits are kept between iterations.
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;
    logic [31:0] rem_step;
    logic [31:0] quot_step;
    logic [31:0] final_q;
    logic [31:0] final_r;

    assign shifted   = {rem_q, quot_q[31]};
    assign diff      = shifted - {1'b0, dvsr_q};
    assign fits      = ~diff[32];
    assign rem_step  = fits ? diff[31:0] : shifted[31:0];
    assign quot_step = {quot_q[30:0], fits};
    assign final_q   = neg_q_q ? -quot_step : quot_step;
    assign final_r   = neg_r_q ? -rem_step  : rem_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = special ? DONE : RUN;
            RUN:  if (cnt_q == 6'd0) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_op_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            rem_q    <= 32'd0;
            quot_q   <= 32'd0;
            dvsr_q   <= 32'd0;
            cnt_q    <= 6'd0;
            result_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        rem_op_q <= op[1];
                        neg_q_q  <= is_signed && (dividend[31] ^ divisor[31]);
                        neg_r_q  <= is_signed && dividend[31];
                        rem_q    <= 32'd0;
                        quot_q   <= abs_dividend;
                        dvsr_q   <= abs_divisor;
                        cnt_q    <= 6'd31;
                        if (div_zero) begin
                            result_q <= op[1] ? dividend : 32'hFFFF_FFFF;
                        end else if (sgn_ovf) begin
                            result_q <= op[1] ? 32'd0 : 32'h8000_0000;
                        end
                    end
                end
                RUN: begin
                    rem_q  <= rem_step;
                    quot_q <= quot_step;
                    if (cnt_q != 6'd0) begin
                        cnt_q <= cnt_q - 6'd1;
                    end else if (!flush) begin
                        result_q <= rem_op_q ? final_r : final_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq. It runs directed RV32M cases, flush/reset
// aborts, back-to-back starts, and a random regression against an arithmetic model.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    div_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // RV32M semantics straight from the ISA rules
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'd0:    return 32'(sa / sb);
            2'd1:    return a / b;
            2'd2:    return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        int   cyc;
        int   busy_cnt;
        int   exp_lat;
        bit   seen;
        logic [31:0] exp;
        exp     = model(o, a, b);
        exp_lat = (b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
        @(posedge clk); #1;
        start = 1'b1; op = o; dividend = a; divisor = b;
        cyc = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
        chk({tag, "_result"}, result, exp);
        @(posedge clk); #1;
        chk({tag, "_done_single"}, {31'd0, done}, 32'd0);
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        int          d1;
        int          d2;
        int          cyc;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0;
        dividend = 32'd0; divisor = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        reset = 1'b0;

        do_op("divu_100_7", 2'd1, 32'd100, 32'd7);
        do_op("remu_100_7", 2'd3, 32'd100, 32'd7);
        do_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2);
        do_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2);
        do_op("rem_7_m2", 2'd2, 32'd7, 32'hFFFF_FFFE);
        do_op("divu_5_0", 2'd1, 32'd5, 32'd0);
        do_op("rem_5_0", 2'd2, 32'd5, 32'd0);
        do_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("rem_m8_2", 2'd2, 32'hFFFF_FFF8, 32'd2);
        do_op("divu_max_1", 2'd1, 32'hFFFF_FFFF, 32'd1);
        do_op("div_m1_3", 2'd0, 32'hFFFF_FFFF, 32'd3);

        // flush in the 10th RUN cycle
        @(posedge clk); #1;
        start = 1'b1; op = 2'd1; dividend = 32'd100; divisor = 32'd7;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("flush_pre_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_done", {31'd0, done}, 32'd0);
        count_done(40, n);
        chk("flush_no_done", 32'(n), 32'd0);
        do_op("after_flush", 2'd0, 32'd1000, 32'hFFFF_FFF9);

        // flush coinciding with start
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = 2'd1; dividend = 32'd9; divisor = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);
        count_done(5, n);
        chk("flush_start_no_done", 32'(n), 32'd0);

        // flush during DONE still shows done that cycle
        @(posedge clk); #1;
        start = 1'b1; op = 2'd1; dividend = 32'd5; divisor = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("flush_done_pulse", {31'd0, done}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_done_after", {31'd0, done}, 32'd0);
        chk("flush_done_busy", {31'd0, busy}, 32'd0);

        // start held high: second op accepted in the IDLE cycle after DONE
        @(posedge clk); #1;
        start = 1'b1; op = 2'd1; dividend = 32'd100; divisor = 32'd7;
        d1 = 0; d2 = 0; n = 0;
        for (cyc = 1; cyc <= 70; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                n++;
                if (n == 1) d1 = cyc;
                if (n == 2) d2 = cyc;
            end
        end
        start = 1'b0;
        chk("b2b_count", 32'(n), 32'd2);
        chk("b2b_first", 32'(d1), 32'd33);
        chk("b2b_second", 32'(d2), 32'd67);
        chk("b2b_result", result, 32'd14);
        repeat (40) @(posedge clk);
        #1;

        // reset in the middle of RUN
        @(posedge clk); #1;
        start = 1'b1; op = 2'd0; dividend = 32'd12345; divisor = 32'd11;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_run_busy", {31'd0, busy}, 32'd0);
        chk("rst_run_done", {31'd0, done}, 32'd0);
        chk("rst_run_result", result, 32'd0);
        reset = 1'b0;
        count_done(40, n);
        chk("rst_run_no_done", 32'(n), 32'd0);

        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0: begin ra = $urandom; rb = 32'd0; end
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 50); rb = $urandom_range(1, 9); end
                3: begin ra = $urandom; rb = -($urandom_range(1, 20)); end
                default: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
            endcase
            do_op("rnd", ro, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
